// File: rtl/drv_segment_scan.sv
// -----------------------------------------------------------------------------
// drv_segment_scan
//   Time-multiplexed driver for a DIGITS-digit hex 7-segment display. One digit
//   is driven per slot of CLK_DIV clocks. The first DEAD clocks of every slot
//   are dark so the previous digit's segments never ghost onto the next anode.
//   Inputs are captured into a snapshot once per frame, on the frame's last
//   clock, so a frame never mixes old and new values.
//
// Ports
//   i_clk        clock
//   i_rst        synchronous reset, active-high (outputs inactive, scan restarts)
//   i_val        nibble k = i_val[4k+3:4k] is shown on digit k (digit 0 = LS)
//   i_en         per-digit enable (0 = digit dark)
//   i_dp         per-digit decimal point request
//   i_blink      per-digit blink request
//   i_lz_blank   1 = blank leading zeros (digit 0 is never blanked)
//   o_drv_sgmnt  segments a..g on bit0..bit6, polarity set by SEG_ACTIVE_LOW
//   o_drv_dp     decimal point, polarity set by SEG_ACTIVE_LOW
//   o_drv_an     digit select, at most one selected, polarity set by AN_ACTIVE_LOW
// -----------------------------------------------------------------------------
module drv_segment_scan #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter int DEAD           = 16,
  parameter int BLINK_FRAMES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [4*DIGITS-1:0]   i_val,
  input  logic [DIGITS-1:0]     i_en,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic [DIGITS-1:0]     i_blink,
  input  logic                  i_lz_blank,
  output logic [6:0]            o_drv_sgmnt,
  output logic                  o_drv_dp,
  output logic [DIGITS-1:0]     o_drv_an
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF   = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Hex glyph in active-low form (0 = segment lit), a..g on bit0..bit6.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    case (nib)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  // Map an active-low segment pattern onto the board's segment polarity.
  function automatic logic [6:0] seg_polarity(input logic [6:0] seg_lo);
    seg_polarity = SEG_ACTIVE_LOW ? seg_lo : ~seg_lo;
  endfunction

  // Scan state
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FRM_W-1:0]    frm_q, frm_d;
  logic                phase_q, phase_d;

  // Frame-coherent input snapshot
  logic [4*DIGITS-1:0] snap_val_q;
  logic [DIGITS-1:0]   snap_en_q;
  logic [DIGITS-1:0]   snap_dp_q;
  logic [DIGITS-1:0]   snap_blink_q;
  logic                snap_lz_q;

  // Registered outputs
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;

  logic                cnt_last;
  logic                frame_end;

  // ---- stage 0: prescaler, digit index, blink frame counter ----
  always_comb begin
    cnt_last  = (cnt_q == CNT_LAST);
    frame_end = cnt_last && (idx_q == IDX_LAST);
    cnt_d     = cnt_last ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    frm_d     = frm_q;
    phase_d   = phase_q;
    if (cnt_last) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    if (frame_end) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  // ---- stage 0: current digit decode from the snapshot ----
  logic [3:0]        nib_k;
  logic              en_k, dp_k, blink_k, lzb_k, nz_seen, lit;
  logic [DIGITS-1:0] sel;

  always_comb begin
    nib_k   = 4'h0;
    en_k    = 1'b0;
    dp_k    = 1'b0;
    blink_k = 1'b0;
    lzb_k   = 1'b0;
    nz_seen = 1'b0;
    // Walk from the most significant digit down: a digit is a leading zero
    // only while no nonzero nibble has been seen at or above it.
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz_seen = nz_seen | (snap_val_q[4*k +: 4] != 4'h0);
      if (int'(idx_q) == k) begin
        nib_k   = snap_val_q[4*k +: 4];
        en_k    = snap_en_q[k];
        dp_k    = snap_dp_q[k];
        blink_k = snap_blink_q[k];
        lzb_k   = snap_lz_q && (k != 0) && !nz_seen;
      end
    end

    lit = (int'(cnt_q) >= DEAD) && en_k && !(blink_k && phase_q) && !lzb_k;

    sel = '0;
    for (int k = 0; k < DIGITS; k++) begin
      sel[k] = lit && (int'(idx_q) == k);
    end

    seg_d = lit ? seg_polarity(hex_glyph(nib_k)) : SEG_OFF;
    dp_d  = (lit && dp_k) ? ~DP_OFF : DP_OFF;
    an_d  = AN_ACTIVE_LOW ? ~sel : sel;
  end

  // ---- stage 0 -> stage 1: registered state and outputs ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      phase_q <= 1'b0;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      an_q    <= AN_OFF;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  // Snapshot tracks the inputs throughout reset so the first frame after
  // release shows current values; afterwards it only updates at frame end.
  always_ff @(posedge i_clk) begin
    if (i_rst || frame_end) begin
      snap_val_q   <= i_val;
      snap_en_q    <= i_en;
      snap_dp_q    <= i_dp;
      snap_blink_q <= i_blink;
      snap_lz_q    <= i_lz_blank;
    end
  end

  assign o_drv_sgmnt = seg_q;
  assign o_drv_dp    = dp_q;
  assign o_drv_an    = an_q;

endmodule

// File: tb/tb_drv_segment_scan.sv
module tb_drv_segment_scan;

  localparam int DG = 4;
  localparam int CD = 4;
  localparam int DT = 1;
  localparam int BF = 2;
  localparam int FRAME = DG * CD;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] val = 16'h0;
  logic [3:0]  en = 4'h0, dp = 4'h0, blink = 4'h0;
  logic        lz = 1'b0;
  logic [6:0]  seg;
  logic        dpo;
  logic [3:0]  an;

  int errors = 0;
  int checks = 0;

  drv_segment_scan #(
    .DIGITS(DG), .CLK_DIV(CD), .DEAD(DT), .BLINK_FRAMES(BF),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_val(val), .i_en(en), .i_dp(dp),
    .i_blink(blink), .i_lz_blank(lz),
    .o_drv_sgmnt(seg), .o_drv_dp(dpo), .o_drv_an(an)
  );

  always #5 clk = ~clk;

  // Reference model: position in the scan is derived from the number of
  // clocks since reset; the snapshot is a copy of the inputs taken at the
  // last clock of each frame.
  int          n_q;
  logic [15:0] sv_q;
  logic [3:0]  se_q, sd_q, sb_q;
  logic        sl_q;
  logic [3:0]  m_an, exp_an;
  logic [6:0]  m_seg, exp_seg;
  logic        m_dp, exp_dp;
  int          md, mc, mph;
  logic        mlit;

  always_comb begin
    md    = (n_q / CD) % DG;
    mc    = n_q % CD;
    mph   = ((n_q / FRAME) / BF) % 2;
    mlit  = (mc >= DT) && se_q[md] && !(sb_q[md] && mph == 1)
            && !(sl_q && md > 0 && (sv_q >> (4 * md)) == 16'h0);
    m_an  = 4'hF;
    m_seg = 7'h7F;
    m_dp  = 1'b1;
    if (mlit) begin
      m_an  = ~(4'b0001 << md);
      m_seg = GLYPH[(sv_q >> (4 * md)) & 16'hF];
      m_dp  = ~sd_q[md];
    end
  end

  always @(posedge clk) begin
    if (rst || (n_q % FRAME == FRAME - 1)) begin
      sv_q <= val; se_q <= en; sd_q <= dp; sb_q <= blink; sl_q <= lz;
    end
    if (rst) begin
      n_q     <= 0;
      exp_an  <= 4'hF;
      exp_seg <= 7'h7F;
      exp_dp  <= 1'b1;
    end else begin
      n_q     <= n_q + 1;
      exp_an  <= m_an;
      exp_seg <= m_seg;
      exp_dp  <= m_dp;
    end
  end

  // One reset edge, then release; the next edge starts scan position 0.
  task automatic reset_release();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    val = 16'h12AF; en = 4'hF; dp = 4'hF; blink = 4'h0; lz = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || dpo !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d an=%b seg=%b dp=%b required an=1111 seg=1111111 dp=1", i, an, seg, dpo);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dpo !== 1'b1) begin
      errors++;
      $display("FAIL reset_release an=%b seg=%b dp=%b required an=1111 seg=1111111 dp=1", an, seg, dpo);
    end
  endtask

  task automatic test_scan();
    logic [6:0] tab [4];
    logic [3:0] ean;
    logic [6:0] eseg;
    tab[0] = 7'b0001110; tab[1] = 7'b0001000; tab[2] = 7'b0100100; tab[3] = 7'b1111001;
    val = 16'h12AF; en = 4'hF; dp = 4'h0; blink = 4'h0; lz = 1'b0;
    reset_release();
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk); #1;
      if (i % CD == 0) begin ean = 4'hF; eseg = 7'h7F; end
      else begin ean = ~(4'b0001 << ((i / CD) % DG)); eseg = tab[(i / CD) % DG]; end
      checks++;
      if (an !== ean || seg !== eseg || dpo !== 1'b1) begin
        errors++;
        $display("FAIL scan i=%0d an=%b seg=%b dp=%b required an=%b seg=%b dp=1", i, an, seg, dpo, ean, eseg);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0] ean;
    logic [6:0] eseg;
    int d;
    val = 16'h0050; en = 4'hF; dp = 4'h0; blink = 4'h0; lz = 1'b1;
    reset_release();
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk); #1;
      d = (i / CD) % DG;
      ean = 4'hF; eseg = 7'h7F;
      if (i % CD != 0 && d == 0) begin ean = 4'b1110; eseg = 7'b1000000; end
      if (i % CD != 0 && d == 1) begin ean = 4'b1101; eseg = 7'b0010010; end
      checks++;
      if (an !== ean || seg !== eseg) begin
        errors++;
        $display("FAIL lz_0050 i=%0d an=%b seg=%b required an=%b seg=%b", i, an, seg, ean, eseg);
      end
    end
    val = 16'h0000;
    reset_release();
    for (int i = 0; i < FRAME; i++) begin
      @(posedge clk); #1;
      d = (i / CD) % DG;
      ean = 4'hF; eseg = 7'h7F;
      if (i % CD != 0 && d == 0) begin ean = 4'b1110; eseg = 7'b1000000; end
      checks++;
      if (an !== ean || seg !== eseg) begin
        errors++;
        $display("FAIL lz_0000 i=%0d an=%b seg=%b required an=%b seg=%b", i, an, seg, ean, eseg);
      end
    end
    lz = 1'b0;
  endtask

  task automatic test_coherence();
    logic [6:0] eseg;
    val = 16'h1111; en = 4'hF; dp = 4'h0; blink = 4'h0; lz = 1'b0;
    reset_release();
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(posedge clk); #1;
      if (i % CD == 0) eseg = 7'h7F;
      else eseg = (i < FRAME) ? 7'b1111001 : 7'b0100100;
      checks++;
      if (seg !== eseg) begin
        errors++;
        $display("FAIL coherence i=%0d seg=%b required seg=%b", i, seg, eseg);
      end
      if (i == CD + 1) val = 16'h2222;  // scan is now on digit 1
    end
  endtask

  task automatic test_blink_dp();
    logic [3:0] ean;
    logic       edp, on;
    int d, f;
    val = 16'h4321; en = 4'hF; dp = 4'b0010; blink = 4'b0001; lz = 1'b0;
    reset_release();
    for (int i = 0; i < 8 * FRAME; i++) begin
      @(posedge clk); #1;
      d = (i / CD) % DG;
      f = i / FRAME;
      on = (i % CD != 0) && !(d == 0 && ((f / BF) % 2) == 1);
      ean = on ? ~(4'b0001 << d) : 4'hF;
      edp = !(on && d == 1);
      checks++;
      if (an !== ean || dpo !== edp) begin
        errors++;
        $display("FAIL blink_dp i=%0d an=%b dp=%b required an=%b dp=%b", i, an, dpo, ean, edp);
      end
    end
    dp = 4'h0; blink = 4'h0;
  endtask

  task automatic test_reset_midframe();
    int waited;
    val = 16'h12AF; en = 4'hF; dp = 4'h0; blink = 4'h0; lz = 1'b0;
    reset_release();
    for (int i = 0; i < 2 * CD + 1; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;  // scan sits at digit 2, count 1
    @(posedge clk); #1;
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || dpo !== 1'b1) begin
      errors++;
      $display("FAIL midframe_reset an=%b seg=%b dp=%b required an=1111 seg=1111111 dp=1", an, seg, dpo);
    end
    rst = 1'b0;
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (an === 4'hF && waited < 40);
    checks++;
    if (waited != DT + 1 || an !== 4'b1110 || seg !== 7'b0001110) begin
      errors++;
      $display("FAIL midframe_restart clocks=%0d an=%b seg=%b required clocks=%0d an=1110 seg=0001110", waited, an, seg, DT + 1);
    end
  endtask

  task automatic test_random();
    val = 16'h0000; en = 4'hF; dp = 4'h0; blink = 4'h0; lz = 1'b0;
    reset_release();
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      checks++;
      if (an !== exp_an || seg !== exp_seg || dpo !== exp_dp) begin
        errors++;
        $display("FAIL random i=%0d an=%b seg=%b dp=%b required an=%b seg=%b dp=%b", i, an, seg, dpo, exp_an, exp_seg, exp_dp);
      end
      checks++;
      if ($countones(~an) > 1) begin
        errors++;
        $display("FAIL onehot i=%0d an=%b required at most one selected", i, an);
      end
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 5) == 0) begin
        val = 16'($urandom);
        if ($urandom_range(0, 2) == 0) val = val & 16'h00FF;
        if ($urandom_range(0, 3) == 0) val = 16'h0;
        en    = 4'($urandom);
        dp    = 4'($urandom);
        blink = 4'($urandom);
        lz    = 1'($urandom);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_leading_zero();
    test_coherence();
    test_blink_dp();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/drv_segment_scan.md
Name: drv_segment_scan

Overview:
Time-multiplexed driver for a DIGITS-digit common-anode/cathode 7-segment hex display.
- Cycles through digits, one slot per CLK_DIV clocks.
- Decodes each nibble with the standard hex glyph map.
- Adds per-digit enable, decimal point, blink, leading-zero blanking, anti-ghosting dead time and frame-coherent input capture.
- Sits between datapath/debug registers and the board display pins.

Parameters:
DIGITS, 4, number of digits; ≥1.
CLK_DIV, 50000, clocks per digit slot; ≥2.
DEAD, 16, blanking clocks at start of each slot; 0 ≤ DEAD < CLK_DIV.
BLINK_FRAMES, 64, full scan frames per blink half-period; ≥1.
SEG_ACTIVE_LOW, 1, 1: segment/dp outputs low = lit; 0: high = lit.
AN_ACTIVE_LOW, 1, 1: anode output low = selected; 0: high = selected.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_val  in  4*DIGITS  nibble k = i_val[4k+3:4k] shown on digit k; digit 0 = least significant
i_en  in  DIGITS  per-digit enable; 0 = digit dark
i_dp  in  DIGITS  per-digit decimal point request
i_blink  in  DIGITS  per-digit blink request
i_lz_blank  in  1  1 = blank leading zeros
o_drv_sgmnt  out  7  segments, bit0=a (top) … bit6=g (middle)
o_drv_dp  out  1  decimal point
o_drv_an  out  DIGITS  digit select, one-hot when active

Behaviour:
- Reset (i_rst=1 at edge):
  - cnt=0, idx=0, frame counter=0, blink phase=0 (visible).
  - All outputs inactive: o_drv_an all deselected, o_drv_sgmnt all off (7'b1111111 when SEG_ACTIVE_LOW), o_drv_dp off.
- Snapshot:
  - Internal copy of i_val/i_en/i_dp/i_blink/i_lz_blank, loaded every cycle while i_rst=1.
  - Otherwise loaded only on the last cycle of a frame (idx=DIGITS-1, cnt=CLK_DIV-1).
  - Display never tears mid-frame; input changes appear on the next frame.
- Prescaler cnt counts 0..CLK_DIV-1, then wraps to 0.
- idx advances by 1 on wrap, DIGITS-1 → 0.
- Frame counter increments when idx wraps.
- Blink phase toggles and frame counter clears when the frame counter reaches BLINK_FRAMES-1 at a frame end.
- Outputs are registered, 1-cycle latency: outputs after edge t+1 are a function of cnt, idx, snapshot and phase held during cycle t.
- Digit k = idx is dark (anode deselected, segments and dp off) if any of:
  - cnt < DEAD (dead time);
  - snapshot en[k]=0;
  - blink[k]=1 and phase=1;
  - leading-zero blanked.
- Leading-zero blanking, with lz_blank=1:
  - digit k is blanked iff k>0 and every nibble j ≥ k is 0;
  - digit 0 is never blanked, so value 0 shows a single "0";
  - enable and blink do not affect the zero test.
- Otherwise:
  - anode k selected, all others deselected;
  - segments = hex glyph of nibble k;
  - dp lit iff dp[k].
- Glyphs, active-low form (a..g = bit0..bit6):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - SEG_ACTIVE_LOW=0 inverts all segment and dp bits.
  - AN_ACTIVE_LOW=0 inverts the anode bits.
- Never more than one anode selected in any cycle.
- Reset mid-frame aborts the scan: outputs go inactive on the next edge, and the scan restarts at digit 0.

Test Plan:
- Reset: hold i_rst 3 cycles with DIGITS=4, CLK_DIV=4, DEAD=1, active-low → o_drv_an=1111, o_drv_sgmnt=1111111, o_drv_dp=1 during reset and the cycle after release.
- Scan: i_val=16'h12AF, i_en=1111, others 0 → per 4-clock slot: 1 clock dark, then 3 clocks with the following, repeating every 16 clocks:
  - an=1110, seg=0001110;
  - an=1101, seg=0001000;
  - an=1011, seg=0100100;
  - an=0111, seg=1111001.
- Leading zeros: i_lz_blank=1, i_val=16'h0050 → digits 3,2 dark; digit1 seg=0010010; digit0 seg=1000000. With i_val=0, only digit0 lit, showing 1000000.
- Coherence: change i_val from 16'h1111 to 16'h2222 while idx=1 → digits 1..3 of the current frame still show 1; next frame shows 2 on all digits.
- Blink/dp: BLINK_FRAMES=2, i_blink=0001, i_dp=0010 → digit0 lit 2 frames, dark 2 frames, repeating; digit1 o_drv_dp=0 in its lit window; others unaffected.
- Reset mid-frame: assert i_rst at idx=2, cnt=1 → next edge all outputs inactive; after release the first lit anode is digit0 after DEAD clocks.
